// File: rtl/asa_pu_sched_if.sv
// rtl/asa_pu_sched_if.sv - PU request/word lanes, ASA record channel and release port of asa_pu_sched
interface asa_pu_sched_if #(
   parameter int NUM_PU      = 4,
   parameter int DATA_NBITS  = 16,
   parameter int PU_ID_NBITS = (NUM_PU > 1) ? $clog2(NUM_PU) : 1
);
   logic [NUM_PU-1:0]            pu_req;
   logic [NUM_PU-1:0]            pu_valid;
   logic [NUM_PU*DATA_NBITS-1:0] pu_data;
   logic [NUM_PU-1:0]            pu_eop;
   logic                         rel_valid;
   logic [PU_ID_NBITS-1:0]       rel_pu_id;
   logic [NUM_PU-1:0]            pu_gnt;
   logic                         pu_asa_start;
   logic                         pu_asa_valid;
   logic [DATA_NBITS-1:0]        pu_asa_data;
   logic                         pu_asa_eop;
   logic [PU_ID_NBITS-1:0]       pu_asa_pu_id;
   logic                         err_trunc;
   logic                         err_rel;

   modport master (
      output pu_req, pu_valid, pu_data, pu_eop, rel_valid, rel_pu_id,
      input  pu_gnt, pu_asa_start, pu_asa_valid, pu_asa_data, pu_asa_eop,
             pu_asa_pu_id, err_trunc, err_rel
   );

   modport slave (
      input  pu_req, pu_valid, pu_data, pu_eop, rel_valid, rel_pu_id,
      output pu_gnt, pu_asa_start, pu_asa_valid, pu_asa_data, pu_asa_eop,
             pu_asa_pu_id, err_trunc, err_rel
   );
endinterface

// File: rtl/asa_pu_sched.sv
// rtl/asa_pu_sched.sv - round-robin PU->ASA record scheduler with per-PU credit tracking
module asa_pu_sched #(
   parameter int NUM_PU      = 4,
   parameter int DATA_NBITS  = 16,
   parameter int MAX_WORDS   = 6,
   parameter int CREDITS     = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int PU_ID_NBITS = (NUM_PU > 1) ? $clog2(NUM_PU) : 1
) (
   input logic          clk,
   input logic          rst,
   asa_pu_sched_if.slave bus
);
   localparam int WC_NBITS = $clog2(MAX_WORDS) + 1;
   localparam int CR_NBITS = $clog2(CREDITS + 1);
   localparam int GC_NBITS = 3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_POST  = (GAP_CYCLES == 0) ? S_ARB : S_GAP;

   logic [2:0]             state;
   logic [PU_ID_NBITS-1:0] ptr;
   logic [PU_ID_NBITS-1:0] g;
   logic [WC_NBITS-1:0]    wcnt;
   logic [GC_NBITS-1:0]    gapcnt;
   logic [CR_NBITS-1:0]    cnt [NUM_PU];
   logic [NUM_PU-1:0]      gnt;

   logic                   out_start, out_valid, out_eop;
   logic [DATA_NBITS-1:0]  out_data;
   logic [PU_ID_NBITS-1:0] out_id;
   logic                   trunc_r, rel_err_r;

   logic [NUM_PU-1:0]      eligible;
   logic                   any_elig;
   logic [PU_ID_NBITS-1:0] win;
   logic                   g_valid, g_eop, last_slot, rec_done;
   logic [DATA_NBITS-1:0]  g_data;
   logic [NUM_PU-1:0]      inc, dec;

   assign g_valid   = bus.pu_valid[g];
   assign g_eop     = bus.pu_eop[g];
   assign g_data    = bus.pu_data[g*DATA_NBITS +: DATA_NBITS];
   assign last_slot = (wcnt == WC_NBITS'(MAX_WORDS - 1));
   assign rec_done  = (state == S_XFER) && g_valid && (g_eop || last_slot);

   always_comb begin
      for (int i = 0; i < NUM_PU; i++) begin
         eligible[i] = bus.pu_req[i] && (cnt[i] < CR_NBITS'(CREDITS));
         inc[i]      = rec_done && (g == PU_ID_NBITS'(i));
         dec[i]      = bus.rel_valid && (bus.rel_pu_id == PU_ID_NBITS'(i));
      end
   end

   // Scan from the far end so the candidate nearest to ptr is written last and wins.
   always_comb begin
      int idx;
      idx      = 0;
      any_elig = 1'b0;
      win      = '0;
      for (int k = NUM_PU - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_PU;
         if (eligible[idx]) begin
            any_elig = 1'b1;
            win      = PU_ID_NBITS'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         g         <= '0;
         wcnt      <= '0;
         gapcnt    <= '0;
         gnt       <= '0;
         out_start <= 1'b0;
         out_valid <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         trunc_r   <= 1'b0;
      end else begin
         out_start <= 1'b0;
         out_valid <= 1'b0;
         out_eop   <= 1'b0;
         trunc_r   <= 1'b0;
         case (state)
            S_IDLE: if (any_elig) state <= S_ARB;
            S_ARB: begin
               if (any_elig) begin
                  g     <= win;
                  ptr   <= (int'(win) == NUM_PU - 1) ? '0 : win + 1'b1;
                  gnt   <= NUM_PU'(1) << win;
                  wcnt  <= '0;
                  state <= S_XFER;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_XFER: begin
               if (g_valid) begin
                  out_valid <= 1'b1;
                  out_start <= (wcnt == '0);
                  out_data  <= g_data;
                  out_id    <= g;
                  out_eop   <= g_eop || last_slot;
                  wcnt      <= wcnt + 1'b1;
                  if (g_eop) begin
                     gnt    <= '0;
                     gapcnt <= '0;
                     state  <= S_POST;
                  end else if (last_slot) begin
                     trunc_r <= 1'b1;
                     state   <= S_DRAIN;
                  end
               end
            end
            // Grant stays up so the PU can flush the rest of its over-long record.
            S_DRAIN: begin
               if (g_valid && g_eop) begin
                  gnt    <= '0;
                  gapcnt <= '0;
                  state  <= S_POST;
               end
            end
            S_GAP: begin
               if (gapcnt == GC_NBITS'(GAP_CYCLES - 1)) state <= S_ARB;
               else gapcnt <= gapcnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // A record completing and being released in the same cycle leaves the count untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_err_r <= 1'b0;
         for (int i = 0; i < NUM_PU; i++) cnt[i] <= '0;
      end else begin
         rel_err_r <= 1'b0;
         for (int i = 0; i < NUM_PU; i++) begin
            if (inc[i] && !dec[i]) begin
               if (cnt[i] != CR_NBITS'(CREDITS)) cnt[i] <= cnt[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
               if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
               else rel_err_r <= 1'b1;
            end
         end
      end
   end

   assign bus.pu_gnt       = gnt;
   assign bus.pu_asa_start = out_start;
   assign bus.pu_asa_valid = out_valid;
   assign bus.pu_asa_data  = out_data;
   assign bus.pu_asa_eop   = out_eop;
   assign bus.pu_asa_pu_id = out_id;
   assign bus.err_trunc    = trunc_r;
   assign bus.err_rel      = rel_err_r;
endmodule

// File: tb/tb_asa_pu_sched.sv
// tb/tb_asa_pu_sched.sv - randomized record traffic against a transaction-level scheduler model
module tb_asa_pu_sched;
   localparam int NUM_PU = 4;
   localparam int DW     = 16;
   localparam int MAXW   = 6;
   localparam int CRED   = 4;
   localparam int GAP    = 1;
   localparam int IDW    = 2;
   localparam int NREC   = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   asa_pu_sched_if #(.NUM_PU(NUM_PU), .DATA_NBITS(DW), .PU_ID_NBITS(IDW)) bus ();

   asa_pu_sched #(
      .NUM_PU(NUM_PU), .DATA_NBITS(DW), .MAX_WORDS(MAXW),
      .CREDITS(CRED), .GAP_CYCLES(GAP), .PU_ID_NBITS(IDW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic [DW-1:0] dmem [NUM_PU][NREC][16];
   int            lmem [NUM_PU][NREC];
   int            send_idx [NUM_PU];
   int            widx [NUM_PU];

   int            exp_idx [NUM_PU];
   int            cnt_m [NUM_PU];
   int            snap_cnt [NUM_PU];
   logic [NUM_PU-1:0] snap_req, prev_gnt;
   int            ptr_m, owner, k_out, idle, delivered, pend_id;
   logic          pend_rel, seen_eop, mon_en;

   task automatic model_reset();
      for (int i = 0; i < NUM_PU; i++) begin
         widx[i]     = 0;
         cnt_m[i]    = 0;
         snap_cnt[i] = 0;
      end
      snap_req = '0;
      prev_gnt = '0;
      ptr_m    = 0;
      owner    = -1;
      k_out    = 0;
      idle     = 0;
      pend_rel = 1'b0;
      pend_id  = 0;
      seen_eop = 1'b0;
   endtask

   task automatic check_outputs_zero(input string pfx);
      chk({pfx, "_gnt"},   32'(bus.pu_gnt), 0);
      chk({pfx, "_start"}, 32'(bus.pu_asa_start), 0);
      chk({pfx, "_valid"}, 32'(bus.pu_asa_valid), 0);
      chk({pfx, "_data"},  32'(bus.pu_asa_data), 0);
      chk({pfx, "_eop"},   32'(bus.pu_asa_eop), 0);
      chk({pfx, "_id"},    32'(bus.pu_asa_pu_id), 0);
      chk({pfx, "_trunc"}, 32'(bus.err_trunc), 0);
      chk({pfx, "_rel"},   32'(bus.err_rel), 0);
   endtask

   // Granted PUs stream their current record with random stalls; others drive junk.
   task automatic drive_pus();
      for (int i = 0; i < NUM_PU; i++) begin
         bus.pu_req[i] = (send_idx[i] < NREC);
         if (bus.pu_gnt[i] && send_idx[i] < NREC) begin
            bus.pu_valid[i] = ($urandom_range(0, 9) < 7);
            bus.pu_eop[i]   = 1'b0;
            if (bus.pu_valid[i]) begin
               bus.pu_data[i*DW +: DW] = dmem[i][send_idx[i]][widx[i]];
               bus.pu_eop[i] = (widx[i] == lmem[i][send_idx[i]] - 1);
               if (bus.pu_eop[i]) begin
                  widx[i] = 0;
                  send_idx[i]++;
               end else begin
                  widx[i]++;
               end
            end
         end else begin
            bus.pu_valid[i]         = 1'($urandom_range(0, 1));
            bus.pu_eop[i]           = 1'($urandom_range(0, 1));
            bus.pu_data[i*DW +: DW] = DW'($urandom);
         end
      end
   endtask

   always @(negedge clk) begin
      int len, nexp, done_id, exp_win;
      logic exp_rel_err, inc, dec;
      if (mon_en && !rst) begin
         done_id = -1;
         if (bus.pu_asa_valid) begin
            if (owner < 0 || exp_idx[owner] >= NREC) begin
               chk("unexpected_word", 32'(bus.pu_asa_valid), 0);
            end else begin
               len  = lmem[owner][exp_idx[owner]];
               nexp = (len < MAXW) ? len : MAXW;
               chk("start", 32'(bus.pu_asa_start), 32'(k_out == 0));
               if (k_out == 0 && seen_eop) chk("gap_len", 32'(idle >= GAP), 1);
               chk("pu_id", 32'(bus.pu_asa_pu_id), 32'(owner));
               chk("data", 32'(bus.pu_asa_data), 32'(dmem[owner][exp_idx[owner]][k_out]));
               chk("eop", 32'(bus.pu_asa_eop), 32'(k_out == nexp - 1));
               chk("err_trunc", 32'(bus.err_trunc), 32'(k_out == MAXW - 1 && len > MAXW));
               if (k_out == nexp - 1) begin
                  done_id = owner;
                  exp_idx[owner]++;
                  delivered++;
                  k_out    = 0;
                  idle     = 0;
                  seen_eop = 1'b1;
               end else begin
                  k_out++;
               end
            end
         end else begin
            chk("err_trunc_idle", 32'(bus.err_trunc), 0);
            idle++;
         end

         exp_rel_err = 1'b0;
         for (int i = 0; i < NUM_PU; i++) begin
            inc = (done_id == i);
            dec = pend_rel && (pend_id == i);
            if (inc && !dec) cnt_m[i] = (cnt_m[i] + 1 > CRED) ? CRED : cnt_m[i] + 1;
            else if (dec && !inc) begin
               if (cnt_m[i] == 0) exp_rel_err = 1'b1;
               else cnt_m[i]--;
            end
         end
         chk("err_rel", 32'(bus.err_rel), 32'(exp_rel_err));

         chk("gnt_onehot", 32'($countones(bus.pu_gnt) <= 1), 1);
         if (prev_gnt == '0 && bus.pu_gnt != '0) begin
            exp_win = -1;
            for (int k = 0; k < NUM_PU; k++) begin
               int idx;
               idx = (ptr_m + k) % NUM_PU;
               if (exp_win < 0 && snap_req[idx] && snap_cnt[idx] < CRED) exp_win = idx;
            end
            chk("grant", 32'(bus.pu_gnt), (exp_win < 0) ? 0 : (32'd1 << exp_win));
            if (exp_win >= 0) begin
               ptr_m = (exp_win + 1) % NUM_PU;
               owner = exp_win;
               k_out = 0;
            end
         end else if (prev_gnt != '0 && bus.pu_gnt != '0) begin
            chk("gnt_hold", 32'(bus.pu_gnt), 32'(prev_gnt));
         end
         prev_gnt = bus.pu_gnt;
         snap_req = bus.pu_req;
         for (int i = 0; i < NUM_PU; i++) snap_cnt[i] = cnt_m[i];
         pend_rel = bus.rel_valid;
         pend_id  = int'(bus.rel_pu_id);
      end
   end

   initial begin
      int  cyc;
      bit  did_rst, hit;
      mon_en        = 1'b0;
      delivered     = 0;
      rst           = 1'b1;
      bus.pu_req    = '0;
      bus.pu_valid  = '0;
      bus.pu_eop    = '0;
      bus.pu_data   = '0;
      bus.rel_valid = 1'b0;
      bus.rel_pu_id = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         send_idx[i] = 0;
         exp_idx[i]  = 0;
         for (int r = 0; r < NREC; r++) begin
            lmem[i][r] = (r == 0) ? 1 : int'($urandom_range(1, 9));
            for (int w = 0; w < 16; w++) dmem[i][r][w] = DW'($urandom);
         end
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst    = 1'b0;
      mon_en = 1'b1;

      cyc     = 0;
      did_rst = 1'b0;
      while (delivered < NUM_PU * NREC && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         hit = 1'b0;
         for (int i = 0; i < NUM_PU; i++)
            if (bus.pu_gnt[i] && send_idx[i] < NREC && widx[i] == 2 && lmem[i][send_idx[i]] > 3)
               hit = 1'b1;
         if (!did_rst && cyc > 150 && hit) begin
            rst           = 1'b1;
            bus.pu_valid  = '0;
            bus.pu_eop    = '0;
            bus.rel_valid = 1'b0;
            #1;
            check_outputs_zero("midrst");
            model_reset();
            @(posedge clk);
            #1;
            rst     = 1'b0;
            did_rst = 1'b1;
         end
         drive_pus();
         bus.rel_valid = ($urandom_range(0, 2) == 0);
         bus.rel_pu_id = IDW'($urandom_range(0, NUM_PU - 1));
      end
      bus.rel_valid = 1'b0;
      chk("all_delivered", 32'(delivered), NUM_PU * NREC);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
